// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm_if
// Brief    : Control bundle between the multi-cycle sequencer and the RV32
//            datapath (instruction register, PC, regfile, ALU muxes, memory).
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  // Datapath status into the sequencer
  logic [6:0]       opcode;
  logic             br_cond;
  logic             mem_ready;
  // Sequencer strobes and selects out to the datapath
  logic             pc_write;
  logic             ir_write;
  logic             mdr_write;
  logic             iord;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             pc_src;
  logic             trap;
  logic [CNT_W-1:0] retired;

  // Sequencer side
  modport master (
    input  opcode, br_cond, mem_ready,
    output pc_write, ir_write, mdr_write, iord, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           trap, retired
  );

  // Datapath side
  modport slave (
    output opcode, br_cond, mem_ready,
    input  pc_write, ir_write, mdr_write, iord, mem_read, mem_write,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
           trap, retired
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl_fsm
// Brief    : Multi-cycle sequencer for the RV32 subset (LW, SW, R-type,
//            BEQ/BGT, JAL, I-type ALU). Steps a shared ALU and a shared
//            memory port through fetch/decode/execute/memory/writeback,
//            guards every memory wait with a watchdog and counts retirements.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  localparam int              WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  state_t           state_q,    state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] retired_q,  retired_d;

  logic       pc_write_w, ir_write_w, mdr_write_w, iord_w;
  logic       mem_read_w, mem_write_w, reg_write_w, pc_src_w, trap_w;
  logic [1:0] mem_to_reg_w, alu_src_a_w, alu_src_b_w, alu_op_w;
  logic       wait_expired_w;

  // A memory wait that reaches the last allowed cycle with no ready traps.
  assign wait_expired_w = (wait_cnt_q == WC_LAST);

  // Next-state, watchdog, retirement and control decode from registered state
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    retired_d    = retired_q;
    pc_write_w   = 1'b0;
    ir_write_w   = 1'b0;
    mdr_write_w  = 1'b0;
    iord_w       = 1'b0;
    mem_read_w   = 1'b0;
    mem_write_w  = 1'b0;
    reg_write_w  = 1'b0;
    pc_src_w     = 1'b0;
    trap_w       = 1'b0;
    mem_to_reg_w = 2'b00;
    alu_src_a_w  = 2'b00;
    alu_src_b_w  = 2'b00;
    alu_op_w     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_read_w  = 1'b1;
        alu_src_b_w = 2'b10;
        if (bus.mem_ready) begin
          ir_write_w = 1'b1;
          pc_write_w = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired_w) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        // Precompute PC-relative target into ALU out
        alu_src_a_w = 2'b01;
        alu_src_b_w = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_w = 2'b10;
        alu_src_b_w = 2'b01;
        state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_w = 1'b1;
        iord_w     = 1'b1;
        if (bus.mem_ready) begin
          mdr_write_w = 1'b1;
          state_d     = S_MEMWB;
        end else if (wait_expired_w) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_MEMWB: begin
        reg_write_w  = 1'b1;
        mem_to_reg_w = 2'b01;
        retired_d    = retired_q + CNT_W'(1);
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_w = 1'b1;
        iord_w      = 1'b1;
        if (bus.mem_ready) begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (wait_expired_w) begin
          state_d = S_TRAP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_EXEC_R: begin
        alu_src_a_w = 2'b10;
        alu_src_b_w = 2'b00;
        alu_op_w    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a_w = 2'b10;
        alu_src_b_w = 2'b01;
        alu_op_w    = 2'b11;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_w = 1'b1;
        retired_d   = retired_q + CNT_W'(1);
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1/rs2; target already sits in ALU out from DECODE
        alu_src_a_w = 2'b10;
        alu_op_w    = 2'b01;
        pc_src_w    = 1'b1;
        pc_write_w  = bus.br_cond;
        retired_d   = retired_q + CNT_W'(1);
        state_d     = S_FETCH;
      end
      S_JAL: begin
        reg_write_w  = 1'b1;
        mem_to_reg_w = 2'b10;
        pc_src_w     = 1'b1;
        pc_write_w   = 1'b1;
        retired_d    = retired_q + CNT_W'(1);
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        trap_w = 1'b1;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // State, watchdog and retirement counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  // Strobes are held quiet while reset is asserted
  assign bus.pc_write   = reset ? 1'b0  : pc_write_w;
  assign bus.ir_write   = reset ? 1'b0  : ir_write_w;
  assign bus.mdr_write  = reset ? 1'b0  : mdr_write_w;
  assign bus.iord       = reset ? 1'b0  : iord_w;
  assign bus.mem_read   = reset ? 1'b0  : mem_read_w;
  assign bus.mem_write  = reset ? 1'b0  : mem_write_w;
  assign bus.reg_write  = reset ? 1'b0  : reg_write_w;
  assign bus.mem_to_reg = reset ? 2'b00 : mem_to_reg_w;
  assign bus.alu_src_a  = reset ? 2'b00 : alu_src_a_w;
  assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b_w;
  assign bus.alu_op     = reset ? 2'b00 : alu_op_w;
  assign bus.pc_src     = reset ? 1'b0  : pc_src_w;
  assign bus.trap       = reset ? 1'b0  : trap_w;
  assign bus.retired    = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl_fsm
// Brief    : Scoreboard bench for multicycle_ctrl_fsm. Instructions are
//            expanded into per-cycle phase lists, expected strobes are queued
//            by the driver and popped by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BR, K_JAL, K_ILL} kind_t;
  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                    P_EXR, P_EXI, P_ALUWB, P_BR, P_JAL, P_TRAP} ph_t;

  typedef struct {
    ph_t  ph;
    logic rdy;
    logic fin;
  } cyc_t;

  typedef struct {
    logic [16:0]      outs;
    logic             chk_ret;
    logic [CNT_W-1:0] ret;
    int               cyc;
  } exp_t;

  logic clk;
  logic reset;
  multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc_no = 0;
  logic [CNT_W-1:0] model_ret = '0;

  // Expected control word for one cycle of a phase
  function automatic logic [16:0] exp_out(ph_t ph, logic rdy, logic br);
    logic pcw, irw, mdrw, iord, mr, mw, rw, pcs, tr;
    logic [1:0] m2r, a, b, op;
    pcw = 0; irw = 0; mdrw = 0; iord = 0; mr = 0; mw = 0; rw = 0;
    pcs = 0; tr = 0; m2r = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
    case (ph)
      P_FETCH:  begin mr = 1; b = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE: begin a = 2'b01; b = 2'b01; end
      P_MEMADR: begin a = 2'b10; b = 2'b01; end
      P_MEMRD:  begin mr = 1; iord = 1; mdrw = rdy; end
      P_MEMWB:  begin rw = 1; m2r = 2'b01; end
      P_MEMWR:  begin mw = 1; iord = 1; end
      P_EXR:    begin a = 2'b10; b = 2'b00; op = 2'b10; end
      P_EXI:    begin a = 2'b10; b = 2'b01; op = 2'b11; end
      P_ALUWB:  begin rw = 1; end
      P_BR:     begin a = 2'b10; op = 2'b01; pcs = 1; pcw = br; end
      P_JAL:    begin rw = 1; m2r = 2'b10; pcs = 1; pcw = 1; end
      P_TRAP:   begin tr = 1; end
      default:  begin end
    endcase
    return {pcw, irw, mdrw, iord, mr, mw, rw, m2r, a, b, op, pcs, tr};
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in it
  task automatic drive(input logic rst_in, input logic [6:0] op, input logic br,
                       input logic rdy, input logic [16:0] outs, input logic chk_ret);
    exp_t e;
    reset         = rst_in;
    bus.opcode    = op;
    bus.br_cond   = br;
    bus.mem_ready = rdy;
    e.outs    = outs;
    e.chk_ret = chk_ret;
    e.ret     = model_ret;
    e.cyc     = cyc_no;
    sb.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 7'($urandom), 1'($urandom), 1'($urandom), 17'd0, 1'b0);
    model_ret = '0;
  endtask

  // Memory phase: 'waits' cycles without ready, then completion or timeout
  task automatic add_mem(inout cyc_t cs[$], input ph_t ph, input int waits,
                         input logic fin_on_done, inout logic trapped);
    cyc_t c;
    for (int i = 0; i < waits && i < TIMEOUT; i++) begin
      c.ph = ph; c.rdy = 1'b0; c.fin = 1'b0;
      cs.push_back(c);
    end
    if (waits >= TIMEOUT) begin
      trapped = 1'b1;
    end else begin
      c.ph = ph; c.rdy = 1'b1; c.fin = fin_on_done;
      cs.push_back(c);
    end
  endtask

  function automatic logic [6:0] illegal_op();
    logic [6:0] o;
    do o = 7'($urandom);
    while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
           o == OP_BR || o == OP_JAL);
    return o;
  endfunction

  task automatic run_instr(input kind_t k, input int fw, input int mw,
                           input logic br, input int abort_at, input logic [6:0] ill);
    cyc_t       cs[$];
    cyc_t       c;
    logic       trapped;
    logic [6:0] op;
    logic       rdy, b;
    int         n;
    trapped = 1'b0;
    case (k)
      K_LW:    op = OP_LW;
      K_SW:    op = OP_SW;
      K_R:     op = OP_R;
      K_I:     op = OP_I;
      K_BR:    op = OP_BR;
      K_JAL:   op = OP_JAL;
      default: op = ill;
    endcase
    add_mem(cs, P_FETCH, fw, 1'b0, trapped);
    if (!trapped) begin
      c.rdy = 1'b0; c.fin = 1'b0;
      c.ph = P_DECODE; cs.push_back(c);
      case (k)
        K_LW: begin
          c.ph = P_MEMADR; cs.push_back(c);
          add_mem(cs, P_MEMRD, mw, 1'b0, trapped);
          if (!trapped) begin c.ph = P_MEMWB; c.fin = 1'b1; cs.push_back(c); end
        end
        K_SW: begin
          c.ph = P_MEMADR; cs.push_back(c);
          add_mem(cs, P_MEMWR, mw, 1'b1, trapped);
        end
        K_R:   begin c.ph = P_EXR; cs.push_back(c); c.ph = P_ALUWB; c.fin = 1'b1; cs.push_back(c); end
        K_I:   begin c.ph = P_EXI; cs.push_back(c); c.ph = P_ALUWB; c.fin = 1'b1; cs.push_back(c); end
        K_BR:  begin c.ph = P_BR;  c.fin = 1'b1; cs.push_back(c); end
        K_JAL: begin c.ph = P_JAL; c.fin = 1'b1; cs.push_back(c); end
        default: trapped = 1'b1;
      endcase
    end
    if (trapped) begin
      c.ph = P_TRAP; c.rdy = 1'b0; c.fin = 1'b0;
      for (int i = 0; i < 3; i++) cs.push_back(c);
    end
    n = cs.size();
    if (abort_at >= 0 && abort_at < n) n = abort_at;
    for (int i = 0; i < n; i++) begin
      c   = cs[i];
      rdy = (c.ph == P_FETCH || c.ph == P_MEMRD || c.ph == P_MEMWR) ? c.rdy : 1'($urandom);
      b   = (c.ph == P_BR) ? br : 1'($urandom);
      drive(1'b0, (c.ph == P_FETCH) ? 7'($urandom) : op, b, rdy,
            exp_out(c.ph, rdy, b), 1'b1);
      if (c.fin) model_ret = model_ret + 1'b1;
    end
    if (trapped || n < cs.size()) do_reset(1 + int'($urandom_range(1, 0)));
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t       e;
      logic [16:0] got;
      e   = sb.pop_front();
      got = {bus.pc_write, bus.ir_write, bus.mdr_write, bus.iord, bus.mem_read,
             bus.mem_write, bus.reg_write, bus.mem_to_reg, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.pc_src, bus.trap};
      checks++;
      if (got !== e.outs) begin
        errors++;
        $display("FAIL strobes cycle %0d: got %05h expected %05h", e.cyc, got, e.outs);
      end
      if (e.chk_ret) begin
        checks++;
        if (bus.retired !== e.ret) begin
          errors++;
          $display("FAIL retired cycle %0d: got %0d expected %0d", e.cyc, bus.retired, e.ret);
        end
      end
    end
  end

  // Hard stop if the sequence ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int k, fw, mw, ab;
    reset         = 1'b1;
    bus.opcode    = 7'd0;
    bus.br_cond   = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed scenarios
    run_instr(K_R,   0, 0, 1'b0, -1, 7'h7f);   // ADD, zero wait
    run_instr(K_LW,  3, 3, 1'b0, -1, 7'h7f);   // LW, 3 waits each side
    run_instr(K_BR,  0, 0, 1'b0, -1, 7'h7f);   // not taken
    run_instr(K_BR,  0, 0, 1'b1, -1, 7'h7f);   // taken
    run_instr(K_JAL, 0, 0, 1'b0, -1, 7'h7f);
    run_instr(K_I,   1, 0, 1'b0, -1, 7'h7f);
    run_instr(K_ILL, 0, 0, 1'b0, -1, 7'h7f);   // illegal opcode trap, then reset
    run_instr(K_SW,  0, TIMEOUT, 1'b0, -1, 7'h7f);      // watchdog fires
    run_instr(K_SW,  0, TIMEOUT - 1, 1'b0, -1, 7'h7f);  // ready on last wait cycle
    run_instr(K_LW,  TIMEOUT - 1, TIMEOUT - 1, 1'b0, -1, 7'h7f);
    run_instr(K_LW,  0, TIMEOUT, 1'b0, -1, 7'h7f);      // MEMRD timeout
    run_instr(K_R,   TIMEOUT, 0, 1'b0, -1, 7'h7f);      // FETCH timeout
    run_instr(K_LW,  1, 1, 1'b0, 4, 7'h7f);             // reset mid-instruction

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      k  = int'($urandom_range(20, 0));
      if (k > 6) k = k % 6;
      fw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TIMEOUT + 1, TIMEOUT - 2))
                                       : int'($urandom_range(3, 0));
      mw = ($urandom_range(9, 0) == 0) ? int'($urandom_range(TIMEOUT + 1, TIMEOUT - 2))
                                       : int'($urandom_range(3, 0));
      ab = ($urandom_range(24, 0) == 0) ? int'($urandom_range(6, 0)) : -1;
      run_instr(kind_t'(k), fw, mw, 1'($urandom), ab, illegal_op());
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
